reg_file_param: RTL
===================

Name: reg_file_param

Overview:
Parametrised successor of the 8x8 processor register file: WIDTH-bit x DEPTH-entry storage with one write port and two combinational read ports.
- Adds optional write-to-read bypass and an optional hardwired-zero register 0.
- Adds a sequenced synchronous clear engine that sweeps one entry per cycle under a BUSY flag, with write-rejection reporting.
- Sits between the instruction decoder/control unit and the ALU in the CPU datapath.

Parameters:
WIDTH, 8, data width of each register
DEPTH, 8, number of registers (2..256, need not be a power of two)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads show stored value only
ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are silently discarded

Ports:
CLK  input  1  clock; all state changes on posedge except reset
RESET  input  1  asynchronous, active-low reset
IN  input  WIDTH  write data
INADDRESS  input  ADDR_W  write address
WRITE  input  1  write enable, sampled at posedge CLK
OUT1ADDRESS  input  ADDR_W  read port 1 address
OUT2ADDRESS  input  ADDR_W  read port 2 address
OUT1  output  WIDTH  read port 1 data (combinational)
OUT2  output  WIDTH  read port 2 data (combinational)
CLEAR  input  1  request a sequenced clear of all entries, sampled at posedge CLK
BUSY  output  1  clear sweep in progress (registered)
WR_ERR  output  1  one-cycle pulse: the previous cycle's write was rejected (registered)

Behaviour:
- Reset (RESET=0, asynchronous): all DEPTH entries = 0; FSM = IDLE; sweep pointer = 0; BUSY = 0; WR_ERR = 0. Entries hold 0 while RESET=0. Reset mid-sweep aborts the sweep immediately.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP at a posedge with CLEAR=1; pointer loads 0.
  - SWEEP: each posedge writes 0 to entry[pointer], then pointer+1.
  - SWEEP -> IDLE at the posedge that clears entry DEPTH-1.
  - BUSY = (state==SWEEP). BUSY rises the cycle after CLEAR is sampled and stays high exactly DEPTH cycles.
  - CLEAR while BUSY=1 is ignored; it does not restart or extend the sweep.
- Write acceptance: at posedge, write accepted iff WRITE=1, state==IDLE, CLEAR=0, INADDRESS<DEPTH. Accepted write sets entry[INADDRESS]=IN.
- Write rejection:
  - WRITE=1 with BUSY=1, CLEAR=1 (CLEAR has priority) or INADDRESS>=DEPTH: storage unchanged; WR_ERR=1 for the following cycle only.
  - ZERO_REG=1 with INADDRESS=0: write discarded silently, WR_ERR stays 0.
- Read data for OUTn, in priority order:
  1. address>=DEPTH -> 0
  2. ZERO_REG=1 and address=0 -> 0
  3. BYPASS=1, WRITE=1, state==IDLE, CLEAR=0, address==INADDRESS -> IN
  4. otherwise entry[address]
- Reads are purely combinational; no clock latency.
- Reads during a sweep return current stored contents: already-swept entries read 0, unswept entries keep their old value. Bypass never applies while BUSY=1.
- Both read ports may address the same entry, and either may equal INADDRESS.
- Sweep pointer width ADDR_W. It wraps to 0 on return to IDLE and never indexes >= DEPTH.
- No X on OUT1/OUT2 after reset for any address.

Test Plan:
- Reset/write/read, default params: RESET=0 then 1; write 8'hA5 to reg 3 and 8'h3C to reg 7; OUT1ADDRESS=3, OUT2ADDRESS=7 -> OUT1=8'hA5, OUT2=8'h3C; all other regs read 0.
- Bypass: BYPASS=1, reg 2 holds 8'h11; WRITE=1, INADDRESS=2, IN=8'h99, OUT1ADDRESS=2 in the same cycle -> OUT1=8'h99 before the edge, 8'h99 after. With BYPASS=0 -> OUT1=8'h11 before the edge, 8'h99 after.
- Clear sweep: fill regs 0..7 with 8'hFF; pulse CLEAR one cycle -> BUSY high exactly 8 cycles. After k sweep edges, regs 0..k-1 read 0 and reg k reads 8'hFF. BUSY=0 afterwards; all regs read 0.
- Rejected writes:
  - WRITE to reg 5 with 8'h77 while BUSY=1 -> WR_ERR=1 for exactly one cycle; reg 5 reads 0 after the sweep.
  - DEPTH=6, write to address 6 -> WR_ERR pulse; OUT1ADDRESS=6 reads 0.
- Zero register: ZERO_REG=1; write 8'h55 to reg 0 -> OUT1 with address 0 reads 0; WR_ERR stays 0.
- Reset mid-sweep: WIDTH=16, DEPTH=16; fill with 16'hBEEF; start CLEAR; assert RESET=0 after 5 sweep cycles -> BUSY=0 and all regs 0 immediately. Release reset; write 16'h1234 to reg 9 -> accepted, reads 16'h1234.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised WIDTH x DEPTH register file: one write port, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0, sequenced clear sweep.
module reg_file_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WR_ERR
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_err_q, wr_err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic idle_wr;
    logic wr_in_range;
    logic wr_zero_hit;
    logic wr_accept;
    logic rd1_in_range;
    logic rd2_in_range;

    assign idle_wr      = WRITE && (state_q == ST_IDLE) && !CLEAR;
    assign wr_in_range  = {1'b0, INADDRESS} < DEPTH_X;
    assign rd1_in_range = {1'b0, OUT1ADDRESS} < DEPTH_X;
    assign rd2_in_range = {1'b0, OUT2ADDRESS} < DEPTH_X;
    assign wr_zero_hit  = (ZERO_REG != 0) && (INADDRESS == '0);
    assign wr_accept    = idle_wr && wr_in_range && !wr_zero_hit;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        // Zero-register writes are dropped silently, so they do not count as rejections.
        wr_err_d = WRITE && !(idle_wr && wr_in_range);
        mem_d    = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (CLEAR) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_accept && (INADDRESS == ADDR_W'(i))) begin
                mem_d[i] = IN;
            end
            if ((state_q == ST_SWEEP) && (ptr_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_err_q <= wr_err_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Later assignments override earlier ones, giving range > zero-reg > bypass > storage.
    always_comb begin
        OUT1 = '0;
        OUT2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (OUT1ADDRESS == ADDR_W'(i)) begin
                OUT1 = mem_q[i];
            end
            if (OUT2ADDRESS == ADDR_W'(i)) begin
                OUT2 = mem_q[i];
            end
        end
        if ((BYPASS != 0) && idle_wr && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
        if ((BYPASS != 0) && idle_wr && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
        if (!rd1_in_range) begin
            OUT1 = '0;
        end
        if (!rd2_in_range) begin
            OUT2 = '0;
        end
    end

    assign BUSY   = (state_q == ST_SWEEP);
    assign WR_ERR = wr_err_q;

endmodule
